// File: rtl/cpc_boot_pkg.sv
// rtl/cpc_boot_pkg.sv - shared state encoding, defaults and helpers for the boot word feeder
package cpc_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_REQ     = 3'd2,
        ST_ACK_LOW = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } boot_state_t;

    localparam int ROM_WORDS_DEFAULT   = 12288;
    localparam int ACK_TIMEOUT_DEFAULT = 65535;
    localparam int WORD_COUNT_W        = 15;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// rtl/boot_byte_packer.sv - little-endian packer of four image bytes into one 32-bit word
module boot_byte_packer
    import cpc_boot_pkg::*;
(
    input  logic        ck16,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [7:0]  i_byte,
    output logic        o_last,
    output logic [31:0] o_word
);
    logic [1:0]  r_idx;
    logic [23:0] r_shift;

    // Bytes shift in from the top so the first one ends up in bits [7:0].
    always_ff @(posedge ck16) begin
        if (!reset_n || i_clear) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (i_load) begin
            r_idx   <= r_idx + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

    assign o_last = i_load && (r_idx == 2'd3);
    assign o_word = {i_byte, r_shift};

endmodule

// File: rtl/boot_word_feeder.sv
// rtl/boot_word_feeder.sv - boot image feeder: packs bytes into words and hands them over with a four-phase req/ack
module boot_word_feeder
    import cpc_boot_pkg::*;
#(
    parameter int ROM_WORDS   = ROM_WORDS_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                    ck16,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [7:0]              byte_data,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic [31:0]             host_bootdata,
    output logic                    host_bootdata_req,
    input  logic                    host_bootdata_ack,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [WORD_COUNT_W-1:0] word_count
);
    localparam int                      TMO_W     = cnt_width(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0]        TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [WORD_COUNT_W-1:0] LAST_WORD = WORD_COUNT_W'(ROM_WORDS - 1);

    boot_state_t             r_state;
    logic [31:0]             r_bootdata;
    logic                    r_req;
    logic                    r_byte_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [WORD_COUNT_W-1:0] r_word_count;
    logic [TMO_W-1:0]        r_tmo;

    logic        w_idle_like;
    logic        w_load;
    logic        w_last;
    logic [31:0] w_word;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_load      = byte_valid && r_byte_ready;

    boot_byte_packer u_packer (
        .ck16    (ck16),
        .reset_n (reset_n),
        .i_clear (start && w_idle_like),
        .i_load  (w_load),
        .i_byte  (byte_data),
        .o_last  (w_last),
        .o_word  (w_word)
    );

    always_ff @(posedge ck16) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_bootdata   <= '0;
            r_req        <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_tmo        <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        r_state      <= ST_FILL;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_word_count <= '0;
                        r_tmo        <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_last) begin
                        r_state      <= ST_REQ;
                        r_bootdata   <= w_word;
                        r_req        <= 1'b1;
                        r_byte_ready <= 1'b0;
                        r_tmo        <= '0;
                    end
                end
                ST_REQ: begin
                    if (host_bootdata_ack) begin
                        r_state <= ST_ACK_LOW;
                        r_req   <= 1'b0;
                        r_tmo   <= '0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= ST_ERROR;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                ST_ACK_LOW: begin
                    // A word only counts once the loader has released ack.
                    if (!host_bootdata_ack) begin
                        r_word_count <= r_word_count + WORD_COUNT_W'(1);
                        if (r_word_count == LAST_WORD) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_FILL;
                            r_byte_ready <= 1'b1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready        = r_byte_ready;
    assign host_bootdata     = r_bootdata;
    assign host_bootdata_req = r_req;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;
    assign word_count        = r_word_count;

endmodule

// File: tb/tb_boot_word_feeder.sv
// tb/tb_boot_word_feeder.sv - self-checking bench for boot_word_feeder
module tb_boot_word_feeder;

    logic ck16 = 1'b0;
    always #5 ck16 = ~ck16;

    logic       reset_n, start, byte_valid, ack;
    logic [7:0] byte_data;

    logic        rdy_a, req_a, busy_a, done_a, err_a;
    logic [31:0] data_a;
    logic [14:0] wc_a;
    logic        rdy_b, req_b, busy_b, done_b, err_b;
    logic [31:0] data_b;
    logic [14:0] wc_b;

    boot_word_feeder #(.ROM_WORDS(2), .ACK_TIMEOUT(16)) dut_a (
        .ck16(ck16), .reset_n(reset_n), .start(start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(rdy_a), .host_bootdata(data_a),
        .host_bootdata_req(req_a), .host_bootdata_ack(ack), .busy(busy_a),
        .done(done_a), .error(err_a), .word_count(wc_a)
    );

    boot_word_feeder #(.ROM_WORDS(4), .ACK_TIMEOUT(16)) dut_b (
        .ck16(ck16), .reset_n(reset_n), .start(start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(rdy_b), .host_bootdata(data_b),
        .host_bootdata_req(req_b), .host_bootdata_ack(ack), .busy(busy_b),
        .done(done_b), .error(err_b), .word_count(wc_b)
    );

    int total = 0;
    int bad   = 0;

    bit auto_ack = 1'b0;
    bit use_b    = 1'b0;
    int ack_lat  = 1;
    int ack_hold = 1;
    int age      = 0;
    int hold     = 0;

    typedef struct {
        logic        st;
        logic        bv;
        logic [7:0]  bd;
        logic        ak;
        logic        rdy;
        logic        rq;
        logic        bz;
        logic        dn;
        logic [14:0] wc;
        logic        dchk;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic st, input logic bv, input logic [7:0] bd, input logic ak,
                                input logic rdy, input logic rq, input logic bz, input logic dn,
                                input logic [14:0] wc, input logic dchk, input logic [31:0] dat);
        vec_t v;
        v.st = st; v.bv = bv; v.bd = bd; v.ak = ak; v.rdy = rdy; v.rq = rq;
        v.bz = bz; v.dn = dn; v.wc = wc; v.dchk = dchk; v.dat = dat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic fail_bound(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // One clock; the loader model answers req after ack_lat cycles and drops ack ack_hold cycles after req falls.
    task automatic tick();
        logic r;
        @(posedge ck16);
        #1;
        if (auto_ack) begin
            r = use_b ? req_b : req_a;
            if (r) begin
                age++;
                if (age >= ack_lat) ack = 1'b1;
            end else begin
                age = 0;
                if (ack) begin
                    hold++;
                    if (hold >= ack_hold) begin
                        ack  = 1'b0;
                        hold = 0;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; ack = 1'b0; auto_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit sel_b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!(sel_b ? rdy_b : rdy_a) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) fail_bound("push_byte");
        tick();
        byte_valid = 1'b0;
    endtask

    // Whole ROM_WORDS=2 transfer on dut_a; expected words come straight from the byte list.
    task automatic run_transfer(input logic [7:0] bytes [8], input bit toggle, input string tag);
        logic [7:0]  q[$];
        logic [31:0] exp_w [2];
        int          wi, n;
        bit          acc, prev_req, ph;
        wi = 0; n = 0; ph = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(bytes[i]);
        for (int w = 0; w < 2; w++)
            exp_w[w] = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
        use_b = 1'b0; age = 0; hold = 0; ack = 1'b0; auto_ack = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done_a && !err_a && n < 400) begin
            if (toggle) begin
                ph = ~ph;
                byte_valid = ph && (q.size() > 0);
            end else begin
                byte_valid = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            end
            byte_data = (q.size() > 0) ? q[0] : 8'($urandom);
            acc       = byte_valid && rdy_a;
            prev_req  = req_a;
            tick();
            n++;
            if (acc) void'(q.pop_front());
            if (req_a && !prev_req) begin
                if (wi < 2) chk({tag, " word"}, data_a, exp_w[wi]);
                else        chk({tag, " extra word"}, wi, 1);
                wi++;
            end else if (req_a && wi > 0 && wi <= 2) begin
                chk({tag, " word held"}, data_a, exp_w[wi-1]);
            end
            if (!done_a) begin
                chk({tag, " busy"}, busy_a, 1'b1);
                chk({tag, " error"}, err_a, 1'b0);
            end
        end
        if (n >= 400) fail_bound({tag, " transfer"});
        byte_valid = 1'b0; auto_ack = 1'b0; ack = 1'b0;
        chk({tag, " done"}, done_a, 1'b1);
        chk({tag, " busy end"}, busy_a, 1'b0);
        chk({tag, " word_count"}, wc_a, 15'd2);
        chk({tag, " words seen"}, wi, 2);
        chk({tag, " bytes left"}, q.size(), 0);
        chk({tag, " last word kept"}, data_a, exp_w[1]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fixed [8];
        logic [7:0] rb [8];
        int         n;

        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; ack = 1'b0;
        do_reset();
        chk("rst data", data_a, 32'h0);
        chk("rst req", req_a, 1'b0);
        chk("rst ready", rdy_a, 1'b0);
        chk("rst busy", busy_a, 1'b0);
        chk("rst done", done_a, 1'b0);
        chk("rst error", err_a, 1'b0);
        chk("rst word_count", wc_a, 15'd0);

        tbl[0]  = mk(1, 0, 8'h00, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[1]  = mk(0, 1, 8'h11, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[2]  = mk(0, 1, 8'h22, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[3]  = mk(0, 1, 8'h33, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[4]  = mk(0, 1, 8'h44, 0, 0, 1, 1, 0, 15'd0, 1, 32'h44332211);
        tbl[5]  = mk(0, 1, 8'h55, 1, 0, 0, 1, 0, 15'd0, 1, 32'h44332211);
        tbl[6]  = mk(0, 1, 8'h55, 0, 1, 0, 1, 0, 15'd1, 0, 32'h0);
        tbl[7]  = mk(0, 1, 8'h55, 0, 1, 0, 1, 0, 15'd1, 0, 32'h0);
        tbl[8]  = mk(0, 1, 8'h66, 0, 1, 0, 1, 0, 15'd1, 0, 32'h0);
        tbl[9]  = mk(0, 1, 8'h77, 0, 1, 0, 1, 0, 15'd1, 0, 32'h0);
        tbl[10] = mk(0, 1, 8'h88, 0, 0, 1, 1, 0, 15'd1, 1, 32'h88776655);
        tbl[11] = mk(0, 0, 8'h00, 1, 0, 0, 1, 0, 15'd1, 1, 32'h88776655);
        tbl[12] = mk(0, 0, 8'h00, 0, 0, 0, 0, 1, 15'd2, 1, 32'h88776655);
        tbl[13] = mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 15'd2, 1, 32'h88776655);
        tbl[14] = mk(1, 0, 8'h00, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[15] = mk(0, 1, 8'hAA, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[16] = mk(1, 1, 8'hBB, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[17] = mk(0, 1, 8'hCC, 0, 1, 0, 1, 0, 15'd0, 0, 32'h0);
        tbl[18] = mk(0, 1, 8'hDD, 0, 0, 1, 1, 0, 15'd0, 1, 32'hDDCCBBAA);

        for (int i = 0; i < 19; i++) begin
            start = tbl[i].st; byte_valid = tbl[i].bv; byte_data = tbl[i].bd; ack = tbl[i].ak;
            tick();
            chk($sformatf("vec%0d ready", i), rdy_a, tbl[i].rdy);
            chk($sformatf("vec%0d req", i), req_a, tbl[i].rq);
            chk($sformatf("vec%0d busy", i), busy_a, tbl[i].bz);
            chk($sformatf("vec%0d done", i), done_a, tbl[i].dn);
            chk($sformatf("vec%0d error", i), err_a, 1'b0);
            chk($sformatf("vec%0d word_count", i), wc_a, tbl[i].wc);
            if (tbl[i].dchk) chk($sformatf("vec%0d data", i), data_a, tbl[i].dat);
        end
        start = 1'b0; byte_valid = 1'b0; ack = 1'b0;

        do_reset();
        for (int i = 0; i < 8; i++) fixed[i] = 8'(8'h11 * (i + 1));
        ack_lat = 1; ack_hold = 1;
        run_transfer(fixed, 1'b1, "toggle");

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) rb[i] = 8'($urandom);
            ack_lat  = $urandom_range(1, 5);
            ack_hold = $urandom_range(1, 4);
            run_transfer(rb, 1'b0, $sformatf("rand%0d", t));
        end

        // Loader never answers: error exactly ACK_TIMEOUT cycles after req rises.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) push_byte(8'(8'h31 + k), 1'b0);
        chk("tmo req up", req_a, 1'b1);
        n = 0;
        while (!err_a && n < 40) begin
            tick();
            n++;
        end
        chk("tmo cycles", n, 16);
        chk("tmo error", err_a, 1'b1);
        chk("tmo req", req_a, 1'b0);
        chk("tmo word_count", wc_a, 15'd0);
        chk("tmo busy", busy_a, 1'b0);

        // Ack held high well past the handshake.
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) push_byte(8'(8'h41 + k), 1'b0);
        ack = 1'b1;
        tick();
        chk("hold req low", req_a, 1'b0);
        byte_valid = 1'b1; byte_data = 8'h99;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("hold%0d ready", k), rdy_a, 1'b0);
            chk($sformatf("hold%0d word_count", k), wc_a, 15'd0);
            chk($sformatf("hold%0d busy", k), busy_a, 1'b1);
        end
        ack = 1'b0;
        byte_valid = 1'b0;
        tick();
        chk("hold release word_count", wc_a, 15'd1);
        chk("hold release ready", rdy_a, 1'b1);
        ack = 1'b1;
        tick();
        tick();
        chk("ack in fill word_count", wc_a, 15'd1);
        chk("ack in fill ready", rdy_a, 1'b1);
        ack = 1'b0;

        // Reset in REQ after two words on the ROM_WORDS=4 instance.
        do_reset();
        use_b = 1'b1; ack_lat = 1; ack_hold = 1; age = 0; hold = 0; auto_ack = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 8; k++) push_byte(8'(8'h10 + k), 1'b1);
        n = 0;
        while (wc_b != 15'd2 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) fail_bound("two words");
        auto_ack = 1'b0; ack = 1'b0;
        for (int k = 0; k < 4; k++) push_byte(8'(8'h20 + k), 1'b1);
        chk("b req up", req_b, 1'b1);
        chk("b third word", data_b, 32'h23222120);
        chk("b word_count before rst", wc_b, 15'd2);
        reset_n = 1'b0;
        tick();
        chk("b rst req", req_b, 1'b0);
        chk("b rst word_count", wc_b, 15'd0);
        chk("b rst data", data_b, 32'h0);
        chk("b rst busy", busy_b, 1'b0);
        reset_n = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) push_byte(8'(8'hA1 + k), 1'b1);
        chk("b restart req", req_b, 1'b1);
        chk("b restart word", data_b, 32'hA4A3A2A1);
        chk("b restart word_count", wc_b, 15'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_word_feeder.md
BOOT_WORD_FEEDER -- requirements
Module: boot_word_feeder

Interface
REQ-001 Parameter ROM_WORDS, default 12288, number of 32-bit words per boot transfer (48 KB image).
REQ-002 Parameter ACK_TIMEOUT, default 65535, maximum ck16 cycles spent waiting on any single ack edge.
REQ-003 ck16  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset; synchronous, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a transfer.
REQ-006 byte_data  in  8  image byte from the upstream byte source.
REQ-007 byte_valid  in  1  byte_data holds a valid byte.
REQ-008 byte_ready  out  1  feeder accepts a byte this cycle.
REQ-009 host_bootdata  out  32  packed word presented to the core's boot-data loader.
REQ-010 host_bootdata_req  out  1  word-valid request, four-phase.
REQ-011 host_bootdata_ack  in  1  loader acknowledge, four-phase.
REQ-012 busy  out  1  high in FILL, REQ, ACK_LOW.
REQ-013 done  out  1  sticky; all ROM_WORDS words delivered.
REQ-014 error  out  1  sticky; ack timeout occurred.
REQ-015 word_count  out  15  words fully handshaken since the last start.

Function
REQ-016 States: IDLE, FILL, REQ, ACK_LOW, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR + start=1 -> FILL; clear word_count, byte index, done, error, timeout counter.
REQ-018 start while busy is ignored.
REQ-019 byte_ready = 1 only in FILL; a byte transfers on a cycle with byte_valid=1 and byte_ready=1.
REQ-020 Packing is little-endian: byte index k (0..3) goes to host_bootdata[8k+7:8k]; the first byte after FILL entry is index 0.
REQ-021 Transfer at index 3 -> REQ next cycle; host_bootdata_req=1 from the first REQ cycle.
REQ-022 host_bootdata is stable from REQ entry through ACK_LOW exit and never changes while host_bootdata_req=1.
REQ-023 REQ + ack sampled 1 -> host_bootdata_req=0 next cycle, state ACK_LOW.
REQ-024 ACK_LOW + ack sampled 0 -> word_count+1; if the new count equals ROM_WORDS go to DONE (done=1), else go to FILL with byte index 0.
REQ-025 host_bootdata_ack is ignored in IDLE, FILL, DONE and ERROR.
REQ-026 Timeout counter clears on entry to REQ and ACK_LOW and increments each cycle spent there.
REQ-027 Timeout counter reaching ACK_TIMEOUT -> ERROR: error=1, req=0, word_count frozen.
REQ-028 byte_valid gaps of any length in FILL are legal and do not time out.
REQ-029 DONE: byte_ready=0, req=0, busy=0; host_bootdata keeps the last word.
REQ-030 Minimum per-word cost: 4 FILL cycles + 1 REQ cycle (ack returned in the same cycle) + 1 ACK_LOW cycle = 6 cycles.

Reset
REQ-031 reset_n=0 at a clock edge forces IDLE, host_bootdata=0, host_bootdata_req=0, byte_ready=0, busy=0, done=0, error=0, word_count=0, byte index 0, timeout counter 0.
REQ-032 Reset mid-handshake drops req on the next edge with no completion; a partial word is discarded.

Structure
REQ-033 The state encoding and the defaults for ROM_WORDS and ACK_TIMEOUT are defined in the shared cpc_boot_pkg package.
REQ-034 The byte-to-word packer (index counter plus shift register) is a sub-module named boot_byte_packer; the FSM and timeout logic stay in the top module.

Verification
REQ-035 ROM_WORDS=2, bytes 11,22,33,44,55,66,77,88 at full rate, ack one cycle after req -> words 0x44332211 then 0x88776655; done=1; word_count=2.
REQ-036 byte_valid toggled every other cycle -> same words; busy stays 1; error stays 0.
REQ-037 ack never raised, ACK_TIMEOUT=16 -> error=1 exactly 16 cycles after req rises; req=0; word_count=0.
REQ-038 ack held high for 5 cycles after handshake -> no new FILL until ack=0; word_count increments only once.
REQ-039 reset_n=0 asserted in REQ with 2 words delivered -> next cycle req=0, word_count=0; start restarts from byte index 0.
REQ-040 start pulsed during FILL -> ignored; start in DONE -> new transfer, done cleared.
